// File: rtl/vme_pkg.sv
// rtl/vme_pkg.sv - shared constants, state encoding and grant selectors for the VME arbiter
package vme_pkg;

  localparam logic ACTIVE       = 1'b0;
  localparam logic INACTIVE     = 1'b1;
  localparam logic ARB_MODE_PRI = 1'b0;
  localparam logic ARB_MODE_RRS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_BUSY   = 2'd2,
    ST_SETTLE = 2'd3
  } arb_state_e;

  // Fixed priority: the highest requesting level wins (req is active-high here)
  function automatic logic [1:0] pick_pri(input logic [3:0] req);
    logic [1:0] lvl;
    lvl = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) lvl = i[1:0];
    end
    return lvl;
  endfunction

  // Round robin: scan downwards starting one below the last winner, wrapping 0 -> 3
  function automatic logic [1:0] pick_rr(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] lvl;
    logic [1:0] idx;
    logic       found;
    lvl   = 2'd0;
    found = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      idx = last - s[1:0];
      if (!found && req[idx]) begin
        lvl   = idx;
        found = 1'b1;
      end
    end
    return lvl;
  endfunction

endpackage

// File: rtl/vme_bus_arbiter_if.sv
// rtl/vme_bus_arbiter_if.sv - control and backplane signal bundle of the VME arbiter
interface vme_bus_arbiter_if;
  logic       arb_enable;
  logic       arb_mode;
  logic [3:0] vme_br;
  logic       vme_bbsy_in;
  logic [3:0] vme_bgout;
  logic       vme_bclr_out;
  logic [1:0] grant_level;
  logic       bus_owned;
  logic       grant_timeout;

  // Arbiter side
  modport slave (
    input  arb_enable, arb_mode, vme_br, vme_bbsy_in,
    output vme_bgout, vme_bclr_out, grant_level, bus_owned, grant_timeout
  );

  // Board / stimulus side
  modport master (
    output arb_enable, arb_mode, vme_br, vme_bbsy_in,
    input  vme_bgout, vme_bclr_out, grant_level, bus_owned, grant_timeout
  );
endinterface

// File: rtl/vme_sync.sv
// rtl/vme_sync.sv - multi-stage synchroniser presetting to 1 (inactive for active-low lines)
module vme_sync #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the asynchronous input through DEPTH flops; reset parks every stage inactive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '1;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vme_bus_arbiter.sv
// rtl/vme_bus_arbiter.sv - slot-1 VME DTB arbiter with PRI/RRS selection, BCLR and grant timeout
module vme_bus_arbiter
  import vme_pkg::*;
#(
  parameter int GRANT_TIMEOUT = 255,
  parameter int SETTLE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               clock,
  input  logic               reset,
  vme_bus_arbiter_if.slave   bus
);

  localparam int TW = $clog2(GRANT_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(GRANT_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX   = TW'(GRANT_TIMEOUT);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic [3:0] br_s;
  logic [0:0] bbsy_s;
  logic [3:0] req;
  logic [1:0] sel_level;
  logic       higher_req;

  arb_state_e    state_q, state_d;
  logic [3:0]    bgout_q, bgout_d;
  logic          bclr_q, bclr_d;
  logic [1:0]    level_q, level_d;
  logic          owned_q, owned_d;
  logic          tmo_q, tmo_d;
  logic [1:0]    rr_last_q, rr_last_d;
  logic          mode_q, mode_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] settle_q, settle_d;

  vme_sync #(.WIDTH(4), .DEPTH(SYNC_STAGES)) u_sync_br (
    .clk(clock), .rst_n(reset), .d_i(bus.vme_br), .q_o(br_s)
  );

  vme_sync #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_bbsy (
    .clk(clock), .rst_n(reset), .d_i(bus.vme_bbsy_in), .q_o(bbsy_s)
  );

  assign req = ~br_s;

  // Winner for the next IDLE decision; the mode is only honoured when a grant is issued
  always_comb begin
    sel_level = (bus.arb_mode == ARB_MODE_RRS) ? pick_rr(req, rr_last_q) : pick_pri(req);
  end

  // Any requester above the current owner, used to pre-empt via BCLR
  always_comb begin
    higher_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (req[k] && (2'(k) > level_q)) higher_req = 1'b1;
    end
  end

  // Arbitration FSM: next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    bgout_d   = bgout_q;
    bclr_d    = bclr_q;
    level_d   = level_q;
    owned_d   = owned_q;
    tmo_d     = 1'b0;
    rr_last_d = rr_last_q;
    mode_d    = mode_q;
    timer_d   = timer_q;
    settle_d  = settle_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.arb_enable && (|req) && (bbsy_s[0] == INACTIVE)) begin
          bgout_d            = 4'b1111;
          bgout_d[sel_level] = ACTIVE;
          level_d            = sel_level;
          rr_last_d          = sel_level;
          mode_d             = bus.arb_mode;
          timer_d            = '0;
          state_d            = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (bbsy_s[0] == ACTIVE) begin
          bgout_d = 4'b1111;
          owned_d = 1'b1;
          state_d = ST_BUSY;
        end else if (!req[level_q]) begin
          bgout_d  = 4'b1111;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end else if (timer_q == TIMER_LAST) begin
          bgout_d  = 4'b1111;
          tmo_d    = 1'b1;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_BUSY: begin
        if (bbsy_s[0] == INACTIVE) begin
          bclr_d   = INACTIVE;
          owned_d  = 1'b0;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end else if ((mode_q == ARB_MODE_PRI) && higher_req) begin
          bclr_d = ACTIVE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_IDLE;
        else settle_d = settle_q + SW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drives every output inactive immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bgout_q   <= 4'b1111;
      bclr_q    <= INACTIVE;
      level_q   <= 2'd0;
      owned_q   <= 1'b0;
      tmo_q     <= 1'b0;
      rr_last_q <= 2'd0;
      mode_q    <= ARB_MODE_PRI;
      timer_q   <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      bgout_q   <= bgout_d;
      bclr_q    <= bclr_d;
      level_q   <= level_d;
      owned_q   <= owned_d;
      tmo_q     <= tmo_d;
      rr_last_q <= rr_last_d;
      mode_q    <= mode_d;
      timer_q   <= timer_d;
      settle_q  <= settle_d;
    end
  end

  assign bus.vme_bgout     = bgout_q;
  assign bus.vme_bclr_out  = bclr_q;
  assign bus.grant_level   = level_q;
  assign bus.bus_owned     = owned_q;
  assign bus.grant_timeout = tmo_q;

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// tb/tb_vme_bus_arbiter.sv - self-checking bench with behavioural arbiter model and random backplane agent
module tb_vme_bus_arbiter;

  localparam int GT = 255;
  localparam int SC = 2;
  localparam int SS = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  vme_bus_arbiter_if bus();

  vme_bus_arbiter #(.GRANT_TIMEOUT(GT), .SETTLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 grant offered, 2 bus owned, 3 quiet gap
  logic [3:0] br_hist [SS];
  logic       bb_hist [SS];
  int m_phase = 0, m_lvl = 0, m_rr = 0, m_age = 0, m_quiet = 0;
  bit m_rrs = 0, m_clr = 0, m_pulse = 0;

  task automatic model_step();
    logic [3:0] want;
    bit         busy;
    int         pick;
    want    = ~br_hist[SS-1];
    busy    = (bb_hist[SS-1] == 1'b0);
    m_pulse = 0;
    case (m_phase)
      0: if (bus.arb_enable && want != 4'h0 && !busy) begin
           pick = -1;
           if (bus.arb_mode) begin
             for (int step = 1; step <= 4; step++)
               if (pick < 0 && want[(m_rr - step + 4) % 4]) pick = (m_rr - step + 4) % 4;
           end else begin
             for (int k = 3; k >= 0; k--)
               if (pick < 0 && want[k]) pick = k;
           end
           m_lvl = pick; m_rr = pick; m_rrs = bus.arb_mode; m_age = 0; m_phase = 1;
         end
      1: begin
           m_age++;
           if (busy) m_phase = 2;
           else if (!want[m_lvl]) begin m_phase = 3; m_quiet = 0; end
           else if (m_age == GT) begin m_phase = 3; m_quiet = 0; m_pulse = 1; end
         end
      2: if (!busy) begin
           m_phase = 3; m_quiet = 0; m_clr = 0;
         end else if (!m_rrs) begin
           for (int k = m_lvl + 1; k < 4; k++) if (want[k]) m_clr = 1;
         end
      default: begin
           m_quiet++;
           if (m_quiet == SC) m_phase = 0;
         end
    endcase
    for (int i = SS - 1; i > 0; i--) begin
      br_hist[i] = br_hist[i-1];
      bb_hist[i] = bb_hist[i-1];
    end
    br_hist[0] = bus.vme_br;
    bb_hist[0] = bus.vme_bbsy_in;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SS; i++) begin br_hist[i] = 4'hF; bb_hist[i] = 1'b1; end
      m_phase = 0; m_lvl = 0; m_rr = 0; m_age = 0; m_quiet = 0;
      m_rrs = 0; m_clr = 0; m_pulse = 0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison against the model, on the inactive edge
  always @(negedge clock) begin : cmp_blk
    logic [3:0] e_bg;
    logic [1:0] e_lv;
    if (reset) begin
      e_lv = m_lvl[1:0];
      e_bg = (m_phase == 1) ? ~(4'b0001 << e_lv) : 4'hF;
      n_cmp++;
      if ({bus.vme_bgout, bus.vme_bclr_out, bus.grant_level, bus.bus_owned, bus.grant_timeout} !==
          {e_bg, ~m_clr, e_lv, (m_phase == 2), m_pulse}) begin
        n_bad++;
        $display("FAIL model t=%0t: got bgout=%b bclr=%b lvl=%0d owned=%b tmo=%b, want bgout=%b bclr=%b lvl=%0d owned=%b tmo=%b",
                 $time, bus.vme_bgout, bus.vme_bclr_out, bus.grant_level, bus.bus_owned, bus.grant_timeout,
                 e_bg, ~m_clr, e_lv, (m_phase == 2), m_pulse);
      end
      n_cmp++;
      if ($countones(~bus.vme_bgout) > 1) begin
        n_bad++;
        $display("FAIL onehot t=%0t: bgout=%b, want at most one low", $time, bus.vme_bgout);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic random_run(input int cycles);
    int ag, cnt, lvl, b;
    logic [3:0] br;
    logic bb;
    ag = 0; cnt = 0; lvl = 0; br = 4'hF; bb = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      step();
      case (ag)
        0: if (bus.vme_bgout != 4'hF) begin
             for (int k = 0; k < 4; k++) if (!bus.vme_bgout[k]) lvl = k;
             cnt = $urandom_range(0, 6);
             case ($urandom_range(0, 19))
               0:       ag = 3;
               1, 2:    ag = 4;
               default: ag = 1;
             endcase
           end else if ($urandom_range(0, 49) == 0) begin
             bb = 1'b0; cnt = $urandom_range(1, 6); ag = 5;
           end
        1: if (cnt == 0) begin bb = 1'b0; cnt = $urandom_range(2, 12); ag = 2; end else cnt--;
        2: if (cnt == 0) begin
             bb = 1'b1;
             if ($urandom_range(0, 1) == 1) br[lvl] = 1'b1;
             cnt = 3; ag = 6;
           end else cnt--;
        3: if (bus.vme_bgout == 4'hF) ag = 0;
        4: if (cnt == 0) begin br[lvl] = 1'b1; cnt = 3; ag = 6; end else cnt--;
        5: if (cnt == 0) begin bb = 1'b1; cnt = 3; ag = 6; end else cnt--;
        default: if (cnt == 0) ag = 0; else cnt--;
      endcase
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, 3);
        br[b] = ~br[b];
      end
      if ($urandom_range(0, 199) == 0) bus.arb_mode = ~bus.arb_mode;
      if ($urandom_range(0, 149) == 0) bus.arb_enable = ~bus.arb_enable;
      bus.vme_br      = br;
      bus.vme_bbsy_in = bb;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    int w, low_cnt, clr_low, got;
    int rr_exp [5] = '{3, 2, 1, 0, 3};

    bus.arb_enable = 1'b1; bus.arb_mode = 1'b0;
    bus.vme_br = 4'hF; bus.vme_bbsy_in = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("reset_bgout", bus.vme_bgout, 4'hF);
    check("reset_bclr", bus.vme_bclr_out, 1);
    check("reset_level", bus.grant_level, 0);
    check("reset_owned", bus.bus_owned, 0);
    check("reset_tmo", bus.grant_timeout, 0);

    // PRI latency and selection
    bus.vme_br = 4'b1010;
    step(); check("pri_lat_e1", bus.vme_bgout, 4'hF);
    step(); check("pri_lat_e2", bus.vme_bgout, 4'hF);
    step(); check("pri_lat_e3", bus.vme_bgout, 4'b1011);
    check("pri_level", bus.grant_level, 2);
    bus.vme_bbsy_in = 1'b0;
    step(); step(); check("pri_still_granted", bus.vme_bgout, 4'b1011);
    step(); check("pri_busy_bgout", bus.vme_bgout, 4'hF);
    check("pri_busy_owned", bus.bus_owned, 1);
    bus.vme_bbsy_in = 1'b1; bus.vme_br = 4'hF;
    repeat (8) step();

    // BCLR pre-emption of a level-0 owner
    bus.vme_br = 4'b1110;
    repeat (3) step();
    check("l0_grant", bus.vme_bgout, 4'b1110);
    bus.vme_bbsy_in = 1'b0;
    repeat (3) step();
    check("l0_owned", bus.bus_owned, 1);
    bus.vme_br = 4'b0110;
    step(); step(); check("bclr_not_yet", bus.vme_bclr_out, 1);
    step(); check("bclr_asserted", bus.vme_bclr_out, 0);
    bus.vme_bbsy_in = 1'b1; bus.vme_br = 4'b0111;
    step(); step(); check("bclr_held", bus.vme_bclr_out, 0);
    step(); check("bclr_released", bus.vme_bclr_out, 1);
    check("owned_released", bus.bus_owned, 0);
    step(); check("settle_1", bus.vme_bgout, 4'hF);
    step(); check("settle_2", bus.vme_bgout, 4'hF);
    step(); check("regrant_l3", bus.vme_bgout, 4'b0111);
    check("regrant_level", bus.grant_level, 3);
    bus.vme_br = 4'hF;
    repeat (8) step();

    // Asynchronous reset in BUSY with BCLR asserted
    bus.vme_br = 4'b1110;
    repeat (3) step();
    bus.vme_bbsy_in = 1'b0;
    repeat (3) step();
    bus.vme_br = 4'b0110;
    repeat (3) step();
    check("pre_reset_bclr", bus.vme_bclr_out, 0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_bgout", bus.vme_bgout, 4'hF);
    check("async_rst_bclr", bus.vme_bclr_out, 1);
    check("async_rst_owned", bus.bus_owned, 0);
    check("async_rst_level", bus.grant_level, 0);
    bus.vme_br = 4'h0; bus.vme_bbsy_in = 1'b1; bus.arb_mode = 1'b1;
    step();
    reset = 1'b1;

    // RRS rotation with every level requesting
    clr_low = 0;
    for (int t = 0; t < 5; t++) begin
      w = 0;
      while (bus.vme_bgout == 4'hF && w < 40) begin
        step(); w++;
        if (!bus.vme_bclr_out) clr_low++;
      end
      check("rrs_grant_seen", (w < 40), 1);
      got = bus.grant_level;
      check("rrs_order", got, rr_exp[t]);
      bus.vme_bbsy_in = 1'b0;
      w = 0;
      while (!bus.bus_owned && w < 20) begin step(); w++; end
      check("rrs_owned", bus.bus_owned, 1);
      repeat (3) begin step(); if (!bus.vme_bclr_out) clr_low++; end
      bus.vme_bbsy_in = 1'b1;
      w = 0;
      while (bus.bus_owned && w < 20) begin step(); w++; end
      check("rrs_released", bus.bus_owned, 0);
    end
    check("rrs_no_bclr", clr_low, 0);
    bus.vme_br = 4'hF; bus.arb_mode = 1'b0;
    repeat (10) step();

    // Unclaimed grant to level 1 times out
    bus.vme_br = 4'b1101;
    w = 0;
    while (bus.vme_bgout == 4'hF && w < 10) begin step(); w++; end
    check("tmo_grant", bus.vme_bgout, 4'b1101);
    low_cnt = 0;
    while (bus.vme_bgout == 4'b1101 && low_cnt < 400) begin
      low_cnt++;
      check("tmo_no_early_pulse", bus.grant_timeout, 0);
      step();
    end
    check("tmo_low_cycles", low_cnt, 255);
    check("tmo_pulse", bus.grant_timeout, 1);
    step(); check("tmo_pulse_end", bus.grant_timeout, 0);
    check("tmo_settle_a", bus.vme_bgout, 4'hF);
    step(); check("tmo_settle_b", bus.vme_bgout, 4'hF);
    step(); check("tmo_regrant", bus.vme_bgout, 4'b1101);
    bus.vme_br = 4'hF;
    repeat (10) step();

    // arb_enable gating
    bus.arb_enable = 1'b0; bus.vme_br = 4'b1110;
    repeat (10) begin step(); check("disabled_no_grant", bus.vme_bgout, 4'hF); end
    bus.arb_enable = 1'b1;
    step(); check("enabled_grant", bus.vme_bgout, 4'b1110);
    check("enabled_level", bus.grant_level, 0);
    bus.vme_br = 4'hF;
    repeat (10) step();

    random_run(4000);
    bus.vme_br = 4'hF; bus.vme_bbsy_in = 1'b1; bus.arb_enable = 1'b1;
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
